// File: rtl/pps_error_uart.sv
// rtl/pps_error_uart.sv - signed per-second clock error to "+HHHHHHHH\r\n" over 8N1 UART
module pps_error_uart #(
    parameter int CLOCK_PER_SECOND = 10_000_000,
    parameter int BAUD             = 115200,
    parameter int WIDTH            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err_valid,
    input  logic [WIDTH-1:0] err_value,
    output logic             tx,
    output logic             busy,
    output logic             overrun
);

    localparam int BIT_CYCLES = CLOCK_PER_SECOND / BAUD;
    localparam int HEX_DIGITS = WIDTH / 4;
    localparam int LINE_CHARS = HEX_DIGITS + 3;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int XW         = $clog2(LINE_CHARS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [XW-1:0]    char_idx, char_n;
    logic             tx_n, busy_n, ovr_n, load;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic [3:0]       nib;
    logic [7:0]       cur_char;
    logic             bit_end;

    // Character for the current char index, built from the latched sample.
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            if (char_idx == XW'(i + 1)) nib = mag[WIDTH-1-4*i -: 4];
        end
        if (char_idx == '0)
            cur_char = sign ? 8'h2D : 8'h2B;
        else if (char_idx == XW'(LINE_CHARS - 2))
            cur_char = 8'h0D;
        else if (char_idx == XW'(LINE_CHARS - 1))
            cur_char = 8'h0A;
        else if (nib < 4'd10)
            cur_char = 8'h30 + {4'h0, nib};
        else
            cur_char = 8'h37 + {4'h0, nib};
    end

    assign bit_end = (cnt == CW'(BIT_CYCLES - 1));

    // tx_n is the level for the next cycle, so tx itself is a plain flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        char_n  = char_idx;
        tx_n    = tx;
        busy_n  = busy;
        load    = 1'b0;
        ovr_n   = err_valid && (state != IDLE);
        case (state)
            IDLE: begin
                if (err_valid) begin
                    load    = 1'b1;
                    state_n = START;
                    cnt_n   = '0;
                    bit_n   = '0;
                    char_n  = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = '0;
                    tx_n    = cur_char[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = cur_char[bit_idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (char_idx == XW'(LINE_CHARS - 1)) begin
                        state_n = IDLE;
                        char_n  = '0;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = START;
                        char_n  = char_idx + XW'(1);
                        tx_n    = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            sign     <= 1'b0;
            mag      <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            char_idx <= char_n;
            tx       <= tx_n;
            busy     <= busy_n;
            overrun  <= ovr_n;
            if (load) begin
                sign <= err_value[WIDTH-1];
                mag  <= err_value[WIDTH-1] ? (~err_value + WIDTH'(1)) : err_value;
            end
        end
    end

endmodule
